stream_fifo: RTL

- Synchronous valid/ready FIFO that buffers the merged stream leaving the 4-way arbiter stage.
- Sits directly downstream of the arbiter, so that short consumer stalls do not back-pressure the arbiter and freeze its grant rotation.
- First-word-fall-through: the head entry is presented on data_out whenever the FIFO is non-empty.
- Exposes fill level and an almost-full flag for upstream throttling and debug.

---
 rtl/stream_fifo.sv | 84 ++++++++
 1 files changed

// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready FIFO placed behind the 4-way arbiter.
// Every output comes from registered state, so no input reaches an output combinationally.
module stream_fifo #(
    parameter int DW       = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  logic [DW-1:0] data_in,
    output logic          ready_out,
    output logic          valid_out,
    output logic [DW-1:0] data_out,
    input  logic          ready_in,
    output logic [$clog2(DEPTH):0] count,
    output logic          almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_CNT  = PW'(AF_LEVEL);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    logic empty, full, push, pop;
    logic [AW-1:0] wr_idx, rd_idx;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];

    // The wrap bit distinguishes full from empty when the low bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign ready_out   = !full;
    assign valid_out   = !empty;
    assign data_out    = mem_q[rd_idx];
    assign count       = count_q;
    assign almost_full = (count_q >= AF_CNT);

    assign push = valid_in && ready_out;
    assign pop  = valid_out && ready_in;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];

        if (push) begin
            mem_d[wr_idx] = data_in;
            wr_ptr_d      = wr_ptr_q + PTR_ONE;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;

        // Simultaneous push and pop leaves the level unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

endmodule
